vscale_csr_port_arbiter: RTL and testbench
==========================================

// Module: vscale_csr_port_arbiter
// PURPOSE
//  Shares the CSR file's single access port (addr/cmd/wdata/rdata) between the core pipeline and the HTIF PCR
//  host interface. Core accesses win by default; HTIF requests are buffered, granted in a free cycle (or forced
//  via bounded-starvation stall) and returned on a valid/ready response channel. Sits between pipeline/HTIF and CSR file.
// PARAMETERS
//  STARVE_LIMIT  15  consecutive blocked cycles in WAIT_GRANT before HTIF is force-granted (>=1)
//  STARVE_CNT_W  4   width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk                  in   1                 clock, all state on posedge
//  reset                in   1                 asynchronous, active-high reset
//  htif_reset           in   1                 synchronous HTIF-side abort
//  core_csr_cmd         in   `CSR_CMD_WIDTH    core command; `CSR_IDLE = no access
//  core_csr_addr        in   `CSR_ADDR_WIDTH   core CSR address
//  core_csr_wdata       in   `XPR_LEN          core write data
//  core_csr_rdata       out  `XPR_LEN          read data to core (pass-through of csr_rdata)
//  core_stall           out  1                 core must hold its CSR instruction this cycle
//  htif_pcr_req_valid   in   1                 host request valid
//  htif_pcr_req_ready   out  1                 arbiter can accept request
//  htif_pcr_req_rw      in   1                 1 = write, 0 = read
//  htif_pcr_req_addr    in   `CSR_ADDR_WIDTH   host CSR address
//  htif_pcr_req_data    in   `HTIF_PCR_WIDTH   host write data (bits [31:0] used)
//  htif_pcr_resp_valid  out  1                 response valid
//  htif_pcr_resp_ready  in   1                 host accepts response
//  htif_pcr_resp_data   out  `HTIF_PCR_WIDTH   old CSR value, zero-extended
//  csr_addr / csr_cmd / csr_wdata  out  CSR_ADDR_WIDTH / CSR_CMD_WIDTH / XPR_LEN   to CSR file
//  csr_rdata            in   `XPR_LEN          combinational read data from CSR file
// BEHAVIOUR
//  - FSM states IDLE, WAIT_GRANT, RESP. Async reset: IDLE, starve_cnt=0, buffered req=0, resp_data=0.
//  - Reset outputs: req_ready=0 while reset high; resp_valid=0; core_stall=0; csr port = core inputs.
//  - req_ready = (state==IDLE) && !reset; resp_valid = (state==RESP).
//  - IDLE: on req_valid&&req_ready latch rw, addr, data[31:0]; -> WAIT_GRANT; starve_cnt<=0.
//  - WAIT_GRANT, grant = (core_csr_cmd==`CSR_IDLE) || (starve_cnt==STARVE_LIMIT):
//    grant: csr port driven by HTIF for exactly this cycle: csr_cmd = rw ? `CSR_WRITE : `CSR_READ,
//    csr_addr/wdata from buffer; resp_data <= {32'b0, csr_rdata}; -> RESP.
//    core_stall = grant && core_csr_cmd!=`CSR_IDLE (forced grant only).
//    no grant: core drives csr port; starve_cnt <= starve_cnt+1 (saturating).
//  - RESP: hold resp_data stable; on resp_ready -> IDLE (new req accepted earliest next cycle).
//  - All non-granted cycles: csr_* = core_* combinationally; core_stall=0.
//  - core_csr_rdata = csr_rdata always; meaningless to core in a stalled cycle.
//  - HTIF write returns pre-write value (read and write share one cycle; write commits at edge).
//  - Latency, idle core: accept edge -> access next cycle -> resp_valid the cycle after (2 cycles).
//  - htif_reset (sync, priority over all transitions): -> IDLE, starve_cnt=0, buffer dropped;
//    if in WAIT_GRANT no CSR access is issued in that cycle.
//  - Async reset mid-transaction: state/response dropped immediately; no partial CSR write issued.
// TESTING
//  1. Core idle, HTIF read 0x300 after reset -> csr_cmd=`CSR_READ, addr 0x300 one cycle after accept;
//     resp_valid next cycle, resp_data=64'h6.
//  2. HTIF write 0x340 data 64'h12345678_DEADBEEF, mscratch=0x55 -> csr_wdata=0xDEADBEEF, cmd=`CSR_WRITE;
//     resp_data=64'h55; follow-up read returns 64'hDEADBEEF.
//  3. Core cmd non-idle every cycle, HTIF read pending -> 15 blocked cycles, then core_stall=1 for exactly
//     one cycle with HTIF access; core_stall=0 afterwards.
//  4. resp_ready low 10 cycles -> resp_valid/resp_data stable, req_ready=0, second req_valid ignored until
//     handshake; accepted the cycle after.
//  5. htif_reset asserted in WAIT_GRANT with core busy -> IDLE next cycle, no HTIF cmd on csr port, req_ready=1.
//  6. reset pulsed mid-RESP (between edges) -> resp_valid and req_ready drop immediately; IDLE after release.

Source files
------------

// File: rtl/vscale_csr_port_arbiter_if.sv
// Bus bundle for the CSR port arbiter: core CSR request, HTIF PCR request/response
// channels and the shared CSR-file access port.
interface vscale_csr_port_arbiter_if #(
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned CSR_CMD_WIDTH  = 3,
  parameter int unsigned XPR_LEN        = 32,
  parameter int unsigned HTIF_PCR_WIDTH = 64
);
  logic [CSR_CMD_WIDTH-1:0]  core_csr_cmd;
  logic [CSR_ADDR_WIDTH-1:0] core_csr_addr;
  logic [XPR_LEN-1:0]        core_csr_wdata;
  logic [XPR_LEN-1:0]        core_csr_rdata;
  logic                      core_stall;

  logic                      htif_pcr_req_valid;
  logic                      htif_pcr_req_ready;
  logic                      htif_pcr_req_rw;
  logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr;
  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data;
  logic                      htif_pcr_resp_valid;
  logic                      htif_pcr_resp_ready;
  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data;

  logic [CSR_ADDR_WIDTH-1:0] csr_addr;
  logic [CSR_CMD_WIDTH-1:0]  csr_cmd;
  logic [XPR_LEN-1:0]        csr_wdata;
  logic [XPR_LEN-1:0]        csr_rdata;

  // Arbiter side
  modport slave (
    input  core_csr_cmd, core_csr_addr, core_csr_wdata,
    output core_csr_rdata, core_stall,
    input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    output htif_pcr_req_ready,
    output htif_pcr_resp_valid, htif_pcr_resp_data,
    input  htif_pcr_resp_ready,
    output csr_addr, csr_cmd, csr_wdata,
    input  csr_rdata
  );

  // Pipeline / HTIF / CSR-file side
  modport master (
    output core_csr_cmd, core_csr_addr, core_csr_wdata,
    input  core_csr_rdata, core_stall,
    output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    input  htif_pcr_req_ready,
    input  htif_pcr_resp_valid, htif_pcr_resp_data,
    output htif_pcr_resp_ready,
    input  csr_addr, csr_cmd, csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/vscale_csr_port_arbiter.sv
// Shares the single CSR-file port between the core pipeline (default owner) and
// buffered HTIF PCR requests, with a bounded-starvation forced grant.
module vscale_csr_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 15,
  parameter int unsigned STARVE_CNT_W   = 4,
  parameter int unsigned CSR_ADDR_WIDTH = 12,
  parameter int unsigned CSR_CMD_WIDTH  = 3,
  parameter int unsigned XPR_LEN        = 32,
  parameter int unsigned HTIF_PCR_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      htif_reset,
  vscale_csr_port_arbiter_if.slave  bus
);
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE   = '0;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ   = CSR_CMD_WIDTH'(4);
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE  = CSR_CMD_WIDTH'(5);
  localparam logic [STARVE_CNT_W-1:0]  STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, RESP} state_e;

  state_e                    state_q, state_d;
  logic [STARVE_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                      req_rw_q, req_rw_d;
  logic [CSR_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [XPR_LEN-1:0]        req_data_q, req_data_d;
  logic [XPR_LEN-1:0]        resp_data_q, resp_data_d;
  logic                      grant;
  logic                      req_ready;
  logic                      unused_req_hi;

  // Only the low XPR_LEN bits of the host write data reach the CSR file.
  assign unused_req_hi = ^bus.htif_pcr_req_data[HTIF_PCR_WIDTH-1:XPR_LEN];

  always_comb begin
    grant     = (state_q == WAIT_GRANT) && !htif_reset &&
                ((bus.core_csr_cmd == CSR_IDLE) || (starve_cnt_q == STARVE_MAX));
    req_ready = (state_q == IDLE) && !reset;

    bus.csr_cmd    = bus.core_csr_cmd;
    bus.csr_addr   = bus.core_csr_addr;
    bus.csr_wdata  = bus.core_csr_wdata;
    bus.core_stall = 1'b0;
    if (grant) begin
      bus.csr_cmd    = req_rw_q ? CSR_WRITE : CSR_READ;
      bus.csr_addr   = req_addr_q;
      bus.csr_wdata  = req_data_q;
      bus.core_stall = (bus.core_csr_cmd != CSR_IDLE);
    end

    bus.core_csr_rdata      = bus.csr_rdata;
    bus.htif_pcr_req_ready  = req_ready;
    bus.htif_pcr_resp_valid = (state_q == RESP);
    bus.htif_pcr_resp_data  = HTIF_PCR_WIDTH'(resp_data_q);
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    req_rw_d     = req_rw_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    resp_data_d  = resp_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.htif_pcr_req_valid && req_ready) begin
          req_rw_d     = bus.htif_pcr_req_rw;
          req_addr_d   = bus.htif_pcr_req_addr;
          req_data_d   = bus.htif_pcr_req_data[XPR_LEN-1:0];
          starve_cnt_d = '0;
          state_d      = WAIT_GRANT;
        end
      end
      WAIT_GRANT: begin
        // The read value captured here is the pre-write value for HTIF writes.
        if (grant) begin
          resp_data_d = bus.csr_rdata;
          state_d     = RESP;
        end else if (starve_cnt_q != STARVE_MAX) begin
          starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.htif_pcr_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (htif_reset) begin
      state_d      = IDLE;
      starve_cnt_d = '0;
      req_rw_d     = 1'b0;
      req_addr_d   = '0;
      req_data_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      req_rw_q     <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      req_rw_q     <= req_rw_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      resp_data_q  <= resp_data_d;
    end
  end
endmodule

// File: tb/tb_vscale_csr_port_arbiter.sv
// Self-checking bench for vscale_csr_port_arbiter: directed scenarios plus randomized
// HTIF traffic against a transaction-level model with a small CSR-file model.
module tb_vscale_csr_port_arbiter;
  localparam logic [2:0] CSR_IDLE  = 3'd0;
  localparam logic [2:0] CSR_READ  = 3'd4;
  localparam logic [2:0] CSR_WRITE = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic htif_reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  // CSR file model: combinational read, write commits at the clock edge.
  bit   [31:0] csr_mem [4096];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [31:0] poke_data = '0;

  vscale_csr_port_arbiter_if bus ();

  vscale_csr_port_arbiter #(
    .STARVE_LIMIT (15),
    .STARVE_CNT_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .htif_reset (htif_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  assign bus.csr_rdata = csr_mem[bus.csr_addr];

  always @(posedge clk) begin
    if (poke_en) csr_mem[poke_addr] <= poke_data;
    else if (bus.csr_cmd == CSR_WRITE) csr_mem[bus.csr_addr] <= bus.csr_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached, run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.core_csr_cmd        = CSR_IDLE;
    bus.core_csr_addr       = '0;
    bus.core_csr_wdata      = '0;
    bus.htif_pcr_req_valid  = 1'b0;
    bus.htif_pcr_req_rw     = 1'b0;
    bus.htif_pcr_req_addr   = '0;
    bus.htif_pcr_req_data   = '0;
    bus.htif_pcr_resp_ready = 1'b0;
    htif_reset              = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Presents one request for a single cycle; caller guarantees the arbiter is idle.
  task automatic send_req(input logic rw, input logic [11:0] a, input logic [63:0] d);
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = rw;
    bus.htif_pcr_req_addr  = a;
    bus.htif_pcr_req_data  = d;
    @(posedge clk); #1;
    bus.htif_pcr_req_valid = 1'b0;
  endtask

  task automatic finish_resp();
    bus.htif_pcr_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.htif_pcr_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    bus.core_csr_cmd       = CSR_READ;
    bus.core_csr_addr      = 12'h300;
    bus.core_csr_wdata     = 32'hA5A5_0001;
    bus.htif_pcr_req_valid = 1'b1;
    poke(12'h300, 32'h6);
    @(negedge clk);
    n_run++;
    if (bus.htif_pcr_req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_ready got %b want 0", bus.htif_pcr_req_ready);
    end
    n_run++;
    if ({bus.htif_pcr_resp_valid, bus.core_stall} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid_stall got %b want 00", {bus.htif_pcr_resp_valid, bus.core_stall});
    end
    n_run++;
    if ({bus.csr_cmd, bus.csr_addr, bus.csr_wdata} !== {CSR_READ, 12'h300, 32'hA5A5_0001}) begin
      n_fail++; $display("FAIL reset_csr_port got %h want %h", {bus.csr_cmd, bus.csr_addr, bus.csr_wdata},
                         {CSR_READ, 12'h300, 32'hA5A5_0001});
    end
    n_run++;
    if (bus.htif_pcr_resp_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_resp_data got %h want 0", bus.htif_pcr_resp_data);
    end
    n_run++;
    if (bus.core_csr_rdata !== 32'h6) begin
      n_fail++; $display("FAIL core_rdata got %h want 6", bus.core_csr_rdata);
    end
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read_idle();
    idle_inputs();
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = 1'b0;
    bus.htif_pcr_req_addr  = 12'h300;
    bus.htif_pcr_req_data  = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    n_run++;
    if (bus.htif_pcr_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL read_req_ready got %b want 1", bus.htif_pcr_req_ready);
    end
    @(posedge clk); #1;
    bus.htif_pcr_req_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if ({bus.csr_cmd, bus.csr_addr, bus.htif_pcr_resp_valid} !== {CSR_READ, 12'h300, 1'b0}) begin
      n_fail++; $display("FAIL read_access got %h want %h", {bus.csr_cmd, bus.csr_addr, bus.htif_pcr_resp_valid},
                         {CSR_READ, 12'h300, 1'b0});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_run++;
    if ({bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data} !== {1'b1, 64'h6}) begin
      n_fail++; $display("FAIL read_resp got %h want %h", {bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data}, {1'b1, 64'h6});
    end
    finish_resp();
    @(negedge clk);
    n_run++;
    if ({bus.htif_pcr_resp_valid, bus.htif_pcr_req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL read_after_hs got %b want 01", {bus.htif_pcr_resp_valid, bus.htif_pcr_req_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    idle_inputs();
    poke(12'h340, 32'h55);
    send_req(1'b1, 12'h340, 64'h12345678_DEADBEEF);
    @(negedge clk);
    n_run++;
    if ({bus.csr_cmd, bus.csr_addr, bus.csr_wdata} !== {CSR_WRITE, 12'h340, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL write_access got %h want %h", {bus.csr_cmd, bus.csr_addr, bus.csr_wdata},
                         {CSR_WRITE, 12'h340, 32'hDEADBEEF});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_run++;
    if ({bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data} !== {1'b1, 64'h55}) begin
      n_fail++; $display("FAIL write_old_value got %h want %h", {bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data}, {1'b1, 64'h55});
    end
    finish_resp();
    send_req(1'b0, 12'h340, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    n_run++;
    if ({bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data} !== {1'b1, 64'hDEADBEEF}) begin
      n_fail++; $display("FAIL write_readback got %h want %h", {bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data},
                         {1'b1, 64'hDEADBEEF});
    end
    finish_resp();
  endtask

  task automatic test_starvation();
    int blocked = 0;
    bit got = 1'b0;
    idle_inputs();
    bus.core_csr_cmd  = CSR_READ;
    bus.core_csr_addr = 12'h001;
    send_req(1'b0, 12'h300, 64'h0);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.core_stall === 1'b1) begin
        got = 1'b1;
        n_run++;
        if ({bus.csr_cmd, bus.csr_addr} !== {CSR_READ, 12'h300}) begin
          n_fail++; $display("FAIL starve_forced_access got %h want %h", {bus.csr_cmd, bus.csr_addr}, {CSR_READ, 12'h300});
        end
      end else if ({bus.csr_cmd, bus.csr_addr} === {CSR_READ, 12'h001}) begin
        blocked++;
      end
      @(posedge clk); #1;
    end
    n_run++;
    if (!got || blocked != 15) begin
      n_fail++; $display("FAIL starve_blocked_cycles got %0d (granted=%0b) want 15 (granted=1)", blocked, got);
    end
    @(negedge clk);
    n_run++;
    if ({bus.core_stall, bus.csr_cmd, bus.csr_addr, bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data} !==
        {1'b0, CSR_READ, 12'h001, 1'b1, 64'h6}) begin
      n_fail++; $display("FAIL starve_after got %h want %h",
                         {bus.core_stall, bus.csr_cmd, bus.csr_addr, bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data},
                         {1'b0, CSR_READ, 12'h001, 1'b1, 64'h6});
    end
    finish_resp();
    idle_inputs();
  endtask

  task automatic test_back_pressure();
    idle_inputs();
    send_req(1'b0, 12'h340, 64'h0);
    @(posedge clk); #1;
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = 1'b0;
    bus.htif_pcr_req_addr  = 12'h300;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_run++;
      if ({bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data, bus.htif_pcr_req_ready} !== {1'b1, 64'hDEADBEEF, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold cycle %0d got %h want %h", c,
                           {bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data, bus.htif_pcr_req_ready},
                           {1'b1, 64'hDEADBEEF, 1'b0});
      end
      @(posedge clk); #1;
    end
    bus.htif_pcr_resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.htif_pcr_resp_ready = 1'b0;
    @(negedge clk);
    n_run++;
    if ({bus.htif_pcr_req_ready, bus.htif_pcr_resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL bp_release got %b want 10", {bus.htif_pcr_req_ready, bus.htif_pcr_resp_valid});
    end
    @(posedge clk); #1;
    bus.htif_pcr_req_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if ({bus.csr_cmd, bus.csr_addr} !== {CSR_READ, 12'h300}) begin
      n_fail++; $display("FAIL bp_second_access got %h want %h", {bus.csr_cmd, bus.csr_addr}, {CSR_READ, 12'h300});
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_run++;
    if (bus.htif_pcr_resp_data !== 64'h6) begin
      n_fail++; $display("FAIL bp_second_resp got %h want 6", bus.htif_pcr_resp_data);
    end
    finish_resp();
  endtask

  task automatic test_htif_reset();
    int bad = 0;
    idle_inputs();
    bus.core_csr_cmd  = CSR_READ;
    bus.core_csr_addr = 12'h002;
    send_req(1'b1, 12'h340, 64'h99);
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
    end
    htif_reset = 1'b1;
    @(negedge clk);
    n_run++;
    if ({bus.core_stall, bus.csr_cmd, bus.csr_addr} !== {1'b0, CSR_READ, 12'h002}) begin
      n_fail++; $display("FAIL hreset_no_access got %h want %h", {bus.core_stall, bus.csr_cmd, bus.csr_addr},
                         {1'b0, CSR_READ, 12'h002});
    end
    @(posedge clk); #1;
    htif_reset = 1'b0;
    @(negedge clk);
    n_run++;
    if ({bus.htif_pcr_req_ready, bus.htif_pcr_resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL hreset_idle got %b want 10", {bus.htif_pcr_req_ready, bus.htif_pcr_resp_valid});
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.core_stall !== 1'b0 || bus.csr_cmd !== CSR_READ) bad++;
      @(posedge clk); #1;
    end
    n_run++;
    if (bad != 0) begin
      n_fail++; $display("FAIL hreset_quiet got %0d stray cycles want 0", bad);
    end
    idle_inputs();
    n_run++;
    if (csr_mem[12'h340] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL hreset_no_write got %h want deadbeef", csr_mem[12'h340]);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    send_req(1'b0, 12'h300, 64'h0);
    @(posedge clk); #3;
    n_run++;
    if (bus.htif_pcr_resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre got %b want 1", bus.htif_pcr_resp_valid);
    end
    reset = 1'b1;
    #1;
    n_run++;
    if ({bus.htif_pcr_resp_valid, bus.htif_pcr_req_ready, bus.htif_pcr_resp_data} !== {2'b00, 64'h0}) begin
      n_fail++; $display("FAIL areset_drop got %h want 0",
                         {bus.htif_pcr_resp_valid, bus.htif_pcr_req_ready, bus.htif_pcr_resp_data});
    end
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    n_run++;
    if ({bus.htif_pcr_req_ready, bus.htif_pcr_resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL areset_idle got %b want 10", {bus.htif_pcr_req_ready, bus.htif_pcr_resp_valid});
    end
  endtask

  // Model: each request is served in the first WAIT cycle where the core is idle, or
  // in the 16th WAIT cycle regardless; the response carries the CSR value before any write.
  task automatic test_random();
    logic [31:0] shadow [4];
    logic [11:0] alist [4] = '{12'h340, 12'h341, 12'h342, 12'h343};
    int          pct_tab [4] = '{0, 50, 90, 100};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      shadow[i] = $urandom;
      poke(alist[i], shadow[i]);
    end
    for (int t = 0; t < 40; t++) begin
      int          ai    = $urandom_range(0, 3);
      logic        rw    = 1'($urandom_range(0, 1));
      logic [63:0] d     = {$urandom, $urandom};
      int          pct   = pct_tab[$urandom_range(0, 3)];
      int          delay = $urandom_range(0, 3);
      bit          granted = 1'b0;
      logic [63:0] exp_resp;
      send_req(rw, alist[ai], d);
      for (int k = 0; k <= 15 && !granted; k++) begin
        logic        busy = ($urandom_range(0, 99) < pct);
        logic        exp_grant = !busy || (k == 15);
        logic [48:0] got, want;
        bus.core_csr_cmd   = busy ? CSR_READ : CSR_IDLE;
        bus.core_csr_addr  = 12'h700 | 12'($urandom_range(0, 255));
        bus.core_csr_wdata = $urandom;
        @(negedge clk);
        got = {bus.csr_cmd, bus.csr_addr, bus.csr_wdata, bus.core_stall, bus.htif_pcr_resp_valid};
        if (exp_grant) want = {(rw ? CSR_WRITE : CSR_READ), alist[ai], d[31:0], busy, 1'b0};
        else           want = {bus.core_csr_cmd, bus.core_csr_addr, bus.core_csr_wdata, 1'b0, 1'b0};
        n_run++;
        if (got !== want) begin
          n_fail++; $display("FAIL rand_port txn %0d wait %0d got %h want %h", t, k, got, want);
        end
        granted = exp_grant;
        @(posedge clk); #1;
      end
      exp_resp = {32'h0, shadow[ai]};
      if (rw) shadow[ai] = d[31:0];
      bus.core_csr_cmd = CSR_IDLE;
      for (int c = 0; c <= delay; c++) begin
        bus.htif_pcr_resp_ready = (c == delay);
        @(negedge clk);
        n_run++;
        if ({bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data, bus.htif_pcr_req_ready} !== {1'b1, exp_resp, 1'b0}) begin
          n_fail++; $display("FAIL rand_resp txn %0d got %h want %h", t,
                             {bus.htif_pcr_resp_valid, bus.htif_pcr_resp_data, bus.htif_pcr_req_ready},
                             {1'b1, exp_resp, 1'b0});
        end
        @(posedge clk); #1;
      end
      bus.htif_pcr_resp_ready = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (csr_mem[alist[i]] !== shadow[i]) begin
        n_fail++; $display("FAIL rand_final_csr %h got %h want %h", alist[i], csr_mem[alist[i]], shadow[i]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_read_idle();
    test_write();
    test_starvation();
    test_back_pressure();
    test_htif_reset();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
